// File: rtl/instr_sequencer.sv
// Program sequencer: fetches words from a small writable program memory and
// presents each to controlCircuit until it pulses done; stops on HALT_WORD or end of memory.
module instr_sequencer #(
  parameter int             DEPTH     = 16,
  parameter int             AW        = 4,
  parameter int             IW        = 16,
  parameter logic [IW-1:0]  HALT_WORD = 16'hFFFF,
  parameter int             TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          done,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err
);

  localparam int              WDW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]   LAST   = AW'(DEPTH - 1);
  localparam logic [WDW-1:0]  WD_MAX = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_PAUSE,
    S_HALT,
    S_ERR
  } state_e;

  state_e         state_q;
  logic [AW-1:0]  pc_q;
  logic [AW-1:0]  pc_d;
  logic [IW-1:0]  ir_q;
  logic [WDW-1:0] wd_q;
  logic           instr_valid_q;

  logic [IW-1:0]  mem [DEPTH];
  logic [IW-1:0]  rd_q;

  logic stopped;
  logic mem_we;
  logic start_ok;

  assign stopped  = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR);
  assign mem_we   = prog_we && stopped;
  assign start_ok = start && !prog_we && stopped;

  // Memory is addressed with the next pc so mem[pc] is already registered by FETCH.
  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = '0;
    end else if (start_ok) begin
      pc_d = '0;
    end else if (state_q == S_EXEC && done && pc_q != LAST) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
    rd_q <= mem[pc_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      wd_q          <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE, S_HALT, S_ERR: begin
          if (start_ok) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_q <= rd_q;
          wd_q <= '0;
          if (rd_q == HALT_WORD) begin
            state_q <= S_HALT;
          end else begin
            state_q       <= S_EXEC;
            instr_valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          wd_q <= wd_q + 1'b1;
          // done wins over a watchdog expiry in the same cycle
          if (done) begin
            instr_valid_q <= 1'b0;
            if (pc_q == LAST) begin
              state_q <= S_HALT;
            end else if (step_mode) begin
              state_q <= S_PAUSE;
            end else begin
              state_q <= S_FETCH;
            end
          end else if (wd_q == WD_MAX) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_ERR;
          end
        end
        S_PAUSE: begin
          if (step) begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_valid_q ? ir_q : '0;
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_PAUSE);
  assign halted      = (state_q == S_HALT);
  assign timeout_err = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: normal run, full memory, step mode,
// watchdog, write protection and mid-run reset.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        done;
  logic [15:0] instr;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] issued [0:31];
  int          n_issued;
  logic        wrapped;
  logic        saw_halt_word;
  logic        unstable;

  instr_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .step_mode  (step_mode),
    .step       (step),
    .done       (done),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [15:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_instr"}, instr, 16'h0000);
    check_val({tag, "_valid"}, instr_valid, 1'b0);
    check_val({tag, "_pc"}, pc, 4'd0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_halted"}, halted, 1'b0);
    check_val({tag, "_terr"}, timeout_err, 1'b0);
  endtask

  // Starts a run and answers each instruction with done after dly extra EXEC cycles.
  task automatic run_prog(input int dly);
    logic        prev_v;
    logic [15:0] prev_i;
    logic        seen_nz;
    logic        fin;
    int          cnt;
    n_issued      = 0;
    wrapped       = 1'b0;
    saw_halt_word = 1'b0;
    unstable      = 1'b0;
    prev_v        = 1'b0;
    prev_i        = 16'h0000;
    seen_nz       = 1'b0;
    fin           = 1'b0;
    cnt           = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      done = 1'b0;
      if (halted || timeout_err) begin
        fin = 1'b1;
        break;
      end
      if (pc != 4'd0) seen_nz = 1'b1;
      else if (seen_nz) wrapped = 1'b1;
      if (instr_valid) begin
        if (!prev_v) begin
          if (n_issued < 32) issued[n_issued] = instr;
          $display("issue pc=%0d instr=%h", pc, instr);
          n_issued++;
          cnt = 0;
        end else begin
          cnt++;
          if (instr != prev_i) unstable = 1'b1;
        end
        if (instr == 16'hFFFF) saw_halt_word = 1'b1;
        if (cnt == dly) done = 1'b1;
      end
      prev_v = instr_valid;
      prev_i = instr;
    end
    done = 1'b0;
    check_val("run_finished", fin, 1'b1);
  endtask

  initial begin
    int exec_cnt;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0; done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // done outside EXEC is ignored
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("idle_done_busy", busy, 1'b0);

    // normal run terminated by a HALT word
    write_word(4'd0, 16'h0100);
    write_word(4'd1, 16'h0101);
    write_word(4'd2, 16'h0201);
    write_word(4'd3, 16'hFFFF);
    run_prog(3);
    check_val("norm_count", n_issued, 3);
    check_val("norm_i0", issued[0], 16'h0100);
    check_val("norm_i1", issued[1], 16'h0101);
    check_val("norm_i2", issued[2], 16'h0201);
    check_val("norm_pc", pc, 4'd3);
    check_val("norm_halted", halted, 1'b1);
    check_val("norm_busy", busy, 1'b0);
    check_val("norm_no_ffff", saw_halt_word, 1'b0);
    check_val("norm_stable", unstable, 1'b0);

    // full memory, no HALT word, done in the first EXEC cycle
    for (int a = 0; a < 16; a++) write_word(4'(a), 16'h0001);
    run_prog(0);
    check_val("full_count", n_issued, 16);
    check_val("full_pc", pc, 4'd15);
    check_val("full_halted", halted, 1'b1);
    check_val("full_nowrap", wrapped, 1'b0);

    // step mode
    write_word(4'd0, 16'h1111);
    write_word(4'd1, 16'h2222);
    write_word(4'd2, 16'hFFFF);
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("step_fetch_valid", instr_valid, 1'b0);
    tick();
    check_val("step_w0", instr, 16'h1111);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_val("step_exec_ignored_valid", instr_valid, 1'b1);
    check_val("step_exec_ignored_pc", pc, 4'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_val("pause_valid", instr_valid, 1'b0);
      tick();
    end
    check_val("pause_busy", busy, 1'b1);
    check_val("pause_pc", pc, 4'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_val("step_fetch2_valid", instr_valid, 1'b0);
    tick();
    check_val("step_w1_valid", instr_valid, 1'b1);
    check_val("step_w1", instr, 16'h2222);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("step_pause2_busy", busy, 1'b1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check_val("step_halted", halted, 1'b1);
    check_val("step_halt_pc", pc, 4'd2);
    step_mode = 1'b0;

    // watchdog expiry
    write_word(4'd0, 16'h0AAA);
    start = 1'b1;
    tick();
    start = 1'b0;
    exec_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (timeout_err) break;
      if (instr_valid) exec_cnt++;
    end
    check_val("wd_exec_cycles", exec_cnt, 16);
    check_val("wd_terr", timeout_err, 1'b1);
    check_val("wd_valid", instr_valid, 1'b0);
    check_val("wd_busy", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("wd_restart_terr", timeout_err, 1'b0);
    check_val("wd_restart_busy", busy, 1'b1);
    check_val("wd_restart_pc", pc, 4'd0);
    tick();
    check_val("wd_restart_instr", instr, 16'h0AAA);
    exec_cnt = 1;
    while (exec_cnt < 16) begin
      tick();
      exec_cnt++;
    end
    check_val("wd_16th_valid", instr_valid, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("wd_done16_terr", timeout_err, 1'b0);
    check_val("wd_done16_busy", busy, 1'b1);
    check_val("wd_done16_pc", pc, 4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // write protection
    write_word(4'd0, 16'h0100);
    write_word(4'd1, 16'h0101);
    write_word(4'd2, 16'hFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    write_word(4'd1, 16'hDEAD);
    check_val("wp_w0", instr, 16'h0100);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check_val("wp_busy_write_dropped", instr, 16'h0101);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check_val("wp_halted", halted, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    write_word(4'd1, 16'h0BEE);
    start = 1'b0;
    check_val("wp_start_ignored", busy, 1'b0);
    run_prog(1);
    check_val("wp_count", n_issued, 2);
    check_val("wp_i0", issued[0], 16'h0100);
    check_val("wp_idle_write_stored", issued[1], 16'h0BEE);

    // reset in the middle of EXEC
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_val("mid_exec_valid", instr_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    run_prog(2);
    check_val("rerun_count", n_issued, 2);
    check_val("rerun_i0", issued[0], 16'h0100);
    check_val("rerun_i1", issued[1], 16'h0BEE);
    check_val("rerun_pc", pc, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
